mac_unit: RTL and testbench

Parametrised multi-cycle multiply/accumulate unit with architectural HI/LO registers. It implements the MULT/MULTU/MUL, MADD/MADDU/MSUB/MSUBU and MTHI/MTLO operations that the execute stage currently leaves unimplemented. It sits beside the ALU in the execute stage. The pipeline stalls on `Busy`; MFHI/MFLO read `Hi`/`Lo` directly.

---
 rtl/mac_pkg.sv | 39 +++
 rtl/mac_unit_if.sv | 35 +++
 rtl/mac_step.sv | 35 +++
 rtl/mac_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mac_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared types for the multiply/accumulate unit:
//   mac_op_t     - operation codes accepted on the Op input
//   mac_state_t  - iteration FSM states
//   op_is_signed - op works on magnitudes and re-applies the sign at the end
//   op_is_accum  - op folds the product into the existing {Hi,Lo}
// -----------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_MUL   = 4'd2,
        OP_MADD  = 4'd3,
        OP_MADDU = 4'd4,
        OP_MSUB  = 4'd5,
        OP_MSUBU = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mac_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } mac_state_t;

    // MUL keeps only the low half, which is sign-agnostic; it is grouped with
    // the signed ops so its product is formed the same way as MULT.
    function automatic logic op_is_signed(mac_op_t op);
        return op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic op_is_accum(mac_op_t op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/mac_unit_if.sv
// -----------------------------------------------------------------------------
// mac_unit_if
// Request/response bundle between the execute stage and mac_unit.
//   master (pipeline): drives Start, Op, A, B, Flush
//   slave  (mac_unit): drives Busy, Done, Result, Hi, Lo, Z, N, O
// -----------------------------------------------------------------------------
interface mac_unit_if
    import mac_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             Start;
    mac_op_t          Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Flush;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Z;
    logic             N;
    logic             O;

    modport master (
        output Start, Op, A, B, Flush,
        input  Busy, Done, Result, Hi, Lo, Z, N, O
    );

    modport slave (
        input  Start, Op, A, B, Flush,
        output Busy, Done, Result, Hi, Lo, Z, N, O
    );
endinterface

// File: rtl/mac_step.sv
// -----------------------------------------------------------------------------
// mac_step
// One combinational shift-add iteration of the multiplier.
//   a     : multiplicand magnitude (WIDTH)
//   p_in  : {partial product upper half, remaining multiplier bits} (2*WIDTH)
//   p_out : p_in with the low BITS_PER_CYCLE multiplier bits times a added to
//           the upper half, then the whole register shifted right by
//           BITS_PER_CYCLE (2*WIDTH)
// The multiplier drains out of the bottom as finished product bits fill in
// from the top, so after WIDTH/BITS_PER_CYCLE steps p holds the full product.
// -----------------------------------------------------------------------------
module mac_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [2*WIDTH-1:0] p_in,
    output logic [2*WIDTH-1:0] p_out
);
    localparam int SW = WIDTH + BITS_PER_CYCLE;

    // Upper half plus a BITS_PER_CYCLE x WIDTH product never exceeds SW bits.
    logic [SW-1:0] sum;

    assign sum = SW'(p_in[2*WIDTH-1:WIDTH])
               + SW'(a) * SW'(p_in[BITS_PER_CYCLE-1:0]);

    generate
        if (BITS_PER_CYCLE == WIDTH) begin : g_full
            assign p_out = sum;
        end else begin : g_part
            assign p_out = {sum, p_in[WIDTH-1:BITS_PER_CYCLE]};
        end
    endgenerate
endmodule

// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Iterative multiply / multiply-accumulate unit with architectural HI/LO.
//   Clock, Reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : Start/Op/A/B/Flush in; Busy/Done/Result/Hi/Lo/Z/N/O out
// A multiply-class op takes WIDTH/BITS_PER_CYCLE RUN cycles plus one FINISH
// cycle, then pulses Done. MTHI/MTLO write at the accepting edge and pulse
// Done the following cycle. Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module mac_unit
    import mac_pkg::*;
#(
    parameter int WIDTH          = 32,  // even, >= 8
    parameter int BITS_PER_CYCLE = 4    // 1, 2, 4 or 8, divides WIDTH
) (
    input  logic       Clock,
    input  logic       Reset,
    mac_unit_if.slave  bus
);
    localparam int NSTEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(NSTEPS + 1);
    localparam int PW     = 2 * WIDTH;

    mac_state_t        state_q,  state_d;
    mac_op_t           op_q,     op_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [WIDTH-1:0]  a_q,      a_d;
    logic [PW-1:0]     p_q,      p_d;
    logic              neg_q,    neg_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [WIDTH-1:0]  hi_q,     hi_d;
    logic [WIDTH-1:0]  lo_q,     lo_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              z_q,      z_d;
    logic              n_q,      n_d;
    logic              o_q,      o_d;

    logic              accept;
    logic              op_signed;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [PW-1:0]     p_step, prod, hilo, new_hilo;
    logic [PW:0]       sum_ext, diff_ext;

    mac_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .a     (a_q),
        .p_in  (p_q),
        .p_out (p_step)
    );

    // Done-cycle acceptance needs no extra term: FINISH has already returned
    // the FSM to IDLE by the time Done is high.
    assign accept    = bus.Start && !bus.Flush && (state_q == ST_IDLE);
    assign op_signed = op_is_signed(bus.Op);
    assign a_mag     = (op_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_mag     = (op_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    assign prod      = neg_q ? -p_q : p_q;
    assign hilo      = {hi_q, lo_q};
    // The extra MSB is the unsigned carry-out / borrow.
    assign sum_ext   = {1'b0, hilo} + {1'b0, prod};
    assign diff_ext  = {1'b0, hilo} - {1'b0, prod};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        p_d      = p_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        z_d      = z_q;
        n_d      = n_q;
        o_d      = o_q;
        new_hilo = prod;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.Op)
                        OP_MTHI: begin
                            hi_d   = bus.A;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.A;
                            done_d = 1'b1;
                        end
                        default: begin
                            op_d    = bus.Op;
                            a_d     = a_mag;
                            neg_d   = op_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            // Upper half is the cleared partial product; the
                            // multiplier rides in the lower half.
                            p_d     = {{WIDTH{1'b0}}, b_mag};
                            cnt_d   = CNT_W'(NSTEPS - 1);
                            busy_d  = 1'b1;
                            state_d = ST_RUN;
                        end
                    endcase
                end
            end

            ST_RUN: begin
                if (bus.Flush) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    p_d = p_step;
                    if (cnt_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            ST_FINISH: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (!bus.Flush) begin
                    done_d = 1'b1;
                    o_d    = 1'b0;
                    if (op_q == OP_MUL) begin
                        result_d = prod[WIDTH-1:0];
                        z_d      = (prod[WIDTH-1:0] == '0);
                        n_d      = prod[WIDTH-1];
                    end else begin
                        if (op_is_accum(op_q)) begin
                            new_hilo = (op_q inside {OP_MSUB, OP_MSUBU}) ?
                                       diff_ext[PW-1:0] : sum_ext[PW-1:0];
                        end
                        case (op_q)
                            // Signed overflow: operands agree in sign (add) or
                            // disagree (sub) and the result sign flips.
                            OP_MADD:  o_d = (hilo[PW-1] == prod[PW-1]) &&
                                            (new_hilo[PW-1] != hilo[PW-1]);
                            OP_MSUB:  o_d = (hilo[PW-1] != prod[PW-1]) &&
                                            (new_hilo[PW-1] != hilo[PW-1]);
                            OP_MADDU: o_d = sum_ext[PW];
                            OP_MSUBU: o_d = diff_ext[PW];
                            default:  o_d = 1'b0;
                        endcase
                        hi_d = new_hilo[PW-1:WIDTH];
                        lo_d = new_hilo[WIDTH-1:0];
                        z_d  = (new_hilo == '0);
                        n_d  = new_hilo[PW-1];
                    end
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the iteration datapath (a_q, p_q, cnt_q, op_q, neg_q) is reset
    // too, even though it is always reloaded on accept, so a reset mid-RUN
    // leaves no stale X-prone state behind.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULT;
            cnt_q    <= '0;
            a_q      <= '0;
            p_q      <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            o_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            p_q      <= p_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            o_q      <= o_d;
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Result = result_q;
    assign bus.Hi     = hi_q;
    assign bus.Lo     = lo_q;
    assign bus.Z      = z_q;
    assign bus.N      = n_q;
    assign bus.O      = o_q;
endmodule

// File: tb/tb_mac_unit.sv
// -----------------------------------------------------------------------------
// tb_mac_unit
// Two instances (BITS_PER_CYCLE = 4 and 1) share one stimulus set; sel picks
// which one is observed. Expected values come from a 64-bit arithmetic model.
// -----------------------------------------------------------------------------
module tb_mac_unit;
    import mac_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_i, flush_i, sel;
    mac_op_t     op_i;
    logic [W-1:0] a_i, b_i;

    mac_unit_if #(.WIDTH(W)) bus4();
    mac_unit_if #(.WIDTH(W)) bus1();

    assign bus4.Start = start_i;
    assign bus4.Op    = op_i;
    assign bus4.A     = a_i;
    assign bus4.B     = b_i;
    assign bus4.Flush = flush_i;
    assign bus1.Start = start_i;
    assign bus1.Op    = op_i;
    assign bus1.A     = a_i;
    assign bus1.B     = b_i;
    assign bus1.Flush = flush_i;

    mac_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
        .Clock (clk), .Reset (rst), .bus (bus4.slave)
    );
    mac_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
        .Clock (clk), .Reset (rst), .bus (bus1.slave)
    );

    logic         busy_o, done_o, z_o, n_o, o_o;
    logic [W-1:0] hi_o, lo_o, res_o;
    assign busy_o = sel ? bus1.Busy   : bus4.Busy;
    assign done_o = sel ? bus1.Done   : bus4.Done;
    assign z_o    = sel ? bus1.Z      : bus4.Z;
    assign n_o    = sel ? bus1.N      : bus4.N;
    assign o_o    = sel ? bus1.O      : bus4.O;
    assign hi_o   = sel ? bus1.Hi     : bus4.Hi;
    assign lo_o   = sel ? bus1.Lo     : bus4.Lo;
    assign res_o  = sel ? bus1.Result : bus4.Result;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_n;

    logic [W-1:0] m_hi, m_lo, m_res;
    logic         m_z, m_n, m_o;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_res = '0;
        m_z = 1'b0; m_n = 1'b0; m_o = 1'b0;
    endtask

    // Architectural effect of one op, straight from the arithmetic definition.
    task automatic model_op(input mac_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0]        hl, sp, up, r;
        logic signed [64:0] s65;
        logic [64:0]        u65;
        hl = {m_hi, m_lo};
        sp = 64'(longint'($signed(a)) * longint'($signed(b)));
        up = {32'b0, a} * {32'b0, b};
        r  = hl;
        case (op)
            OP_MTHI:  m_hi = a;
            OP_MTLO:  m_lo = a;
            OP_MUL: begin
                m_res = sp[31:0];
                m_z   = (m_res == 0);
                m_n   = m_res[31];
                m_o   = 1'b0;
            end
            default: begin
                case (op)
                    OP_MULT:  begin r = sp; m_o = 1'b0; end
                    OP_MULTU: begin r = up; m_o = 1'b0; end
                    OP_MADD: begin
                        s65 = $signed({hl[63], hl}) + $signed({sp[63], sp});
                        r = s65[63:0]; m_o = s65[64] ^ s65[63];
                    end
                    OP_MSUB: begin
                        s65 = $signed({hl[63], hl}) - $signed({sp[63], sp});
                        r = s65[63:0]; m_o = s65[64] ^ s65[63];
                    end
                    OP_MADDU: begin
                        u65 = {1'b0, hl} + {1'b0, up};
                        r = u65[63:0]; m_o = u65[64];
                    end
                    default: begin  // OP_MSUBU
                        r = hl - up; m_o = (hl < up);
                    end
                endcase
                m_hi = r[63:32];
                m_lo = r[31:0];
                m_z  = (r == 0);
                m_n  = r[63];
            end
        endcase
    endtask

    task automatic check_state(input string tag);
        check({tag, ".hi"},  hi_o,  m_hi);
        check({tag, ".lo"},  lo_o,  m_lo);
        check({tag, ".res"}, res_o, m_res);
        check({tag, ".z"},   z_o,   m_z);
        check({tag, ".n"},   n_o,   m_n);
        check({tag, ".o"},   o_o,   m_o);
    endtask

    // Called at a negedge; returns at the negedge of the Done cycle so the
    // next call issues back-to-back.
    task automatic do_op(input string tag, input mac_op_t op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int   cycles;
        logic busy_ok;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        model_op(op, a, b);
        if (op == OP_MTHI || op == OP_MTLO) begin
            check({tag, ".mt_done"}, done_o, 1'b1);
            check({tag, ".mt_busy"}, busy_o, 1'b0);
        end else begin
            cycles  = 0;
            busy_ok = 1'b1;
            while (!done_o && cycles < 100) begin
                if (!busy_o) busy_ok = 1'b0;
                cycles++;
                @(negedge clk);
            end
            check({tag, ".latency"},   cycles,  cur_n + 1);
            check({tag, ".busy_run"},  busy_ok, 1'b1);
            check({tag, ".busy_done"}, busy_o,  1'b0);
        end
        check_state(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle.done", done_o, 1'b0);
            check("idle.busy", busy_o, 1'b0);
        end
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(5, 0))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic random_ops(input int count);
        mac_op_t op_r;
        for (int i = 0; i < count; i++) begin
            op_r = mac_op_t'(4'($urandom_range(8, 0)));
            do_op("rand", op_r, rand_opnd(), rand_opnd());
            idle(int'($urandom_range(2, 0)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done_seen;
        sel = 1'b0; rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        op_i = OP_MULT; a_i = '0; b_i = '0; cur_n = 8;
        model_reset();
        #1;
        check_state("reset");
        check("reset.busy", busy_o, 1'b0);
        check("reset.done", done_o, 1'b0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        // Full-scale unsigned product.
        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max.hi_k", hi_o, 32'hFFFF_FFFE);
        check("multu_max.lo_k", lo_o, 32'h0000_0001);
        idle(2);

        // Signed product of mixed signs.
        do_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg.hi_k", hi_o, 32'hFFFF_FFFF);
        check("mult_neg.lo_k", lo_o, 32'hFFFF_FFEB);
        check("mult_neg.n_k",  n_o,  1'b1);
        idle(1);

        // MTHI/MTLO then MADD back-to-back: signed overflow into the sign bit.
        do_op("mthi", OP_MTHI, 32'h7FFF_FFFF, '0);
        do_op("mtlo", OP_MTLO, 32'hFFFF_FFFF, '0);
        do_op("madd_ovf", OP_MADD, 32'd1, 32'd1);
        check("madd_ovf.hi_k", hi_o, 32'h8000_0000);
        check("madd_ovf.o_k",  o_o,  1'b1);
        idle(1);

        // Unsigned borrow, then MUL issued in the Done cycle.
        do_op("clr_hi", OP_MTHI, '0, '0);
        do_op("clr_lo", OP_MTLO, '0, '0);
        do_op("msubu_brw", OP_MSUBU, 32'd1, 32'd1);
        check("msubu_brw.lo_k", lo_o, 32'hFFFF_FFFF);
        check("msubu_brw.o_k",  o_o,  1'b1);
        do_op("mul_b2b", OP_MUL, 32'd6, 32'd7);
        check("mul_b2b.res_k", res_o, 32'd42);
        check("mul_b2b.hi_k",  hi_o,  32'hFFFF_FFFF);
        idle(1);

        // Flush in the 4th Busy cycle; a Start during Busy must be ignored.
        start_i = 1'b1; op_i = OP_MULT; a_i = 32'd5; b_i = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        check("flush.busy1", busy_o, 1'b1);
        @(negedge clk);
        start_i = 1'b1; op_i = OP_MTHI; a_i = 32'h1234_5678;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush.busy_low", busy_o, 1'b0);
        check("flush.no_done",  done_o, 1'b0);
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_o) done_seen = 1'b1;
        end
        check("flush.done_seen", done_seen, 1'b0);
        check_state("flush");

        // Asynchronous reset mid-RUN, checked between clock edges.
        start_i = 1'b1; op_i = OP_MULTU; a_i = '1; b_i = '1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_state("async_rst");
        check("async_rst.busy", busy_o, 1'b0);
        check("async_rst.done", done_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        random_ops(40);

        // Same full-scale MULTU on the one-bit-per-cycle instance.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sel   = 1'b1;
        cur_n = 32;
        model_reset();
        check_state("bpc1_reset");
        do_op("bpc1_multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("bpc1_multu.hi_k", hi_o, 32'hFFFF_FFFE);
        check("bpc1_multu.lo_k", lo_o, 32'h0000_0001);
        idle(1);
        random_ops(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
